// File: rtl/execute_muldiv_pkg.sv
// Shared instruction definitions for the execute-stage multi-cycle mul/div unit.
package execute_muldiv_pkg;

  localparam int unsigned LEN_REG     = 16;
  localparam int unsigned LEN_OPECODE = 7;
  localparam int unsigned ACC_W       = LEN_REG + 1;
  localparam int unsigned CNT_W       = $clog2(LEN_REG);

  localparam logic [LEN_OPECODE-1:0] OPC_MUL = 7'b000_0010;
  localparam logic [LEN_OPECODE-1:0] OPC_DIV = 7'b000_0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/execute_muldiv_step.sv
// One iteration of the shared shift-add multiply / restoring divide datapath.
module execute_muldiv_step
  import execute_muldiv_pkg::*;
(
  input  logic               is_div,
  input  logic [ACC_W-1:0]   acc,
  input  logic [LEN_REG-1:0] sreg,
  input  logic [LEN_REG-1:0] operand,
  output logic [ACC_W-1:0]   acc_next_c,
  output logic [LEN_REG-1:0] sreg_next_c,
  output logic               res_bit_c
);

  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] shifted;
  logic [ACC_W:0]   diff;

  always_comb begin
    sum         = acc + ACC_W'(sreg[0] ? operand : '0);
    shifted     = {acc[LEN_REG-1:0], sreg[LEN_REG-1]};
    // Extra top bit of diff is the borrow of the trial subtraction
    diff        = {1'b0, shifted} - (ACC_W+1)'(operand);
    acc_next_c  = '0;
    sreg_next_c = '0;
    res_bit_c   = 1'b0;
    if (is_div) begin
      res_bit_c   = ~diff[ACC_W];
      acc_next_c  = res_bit_c ? diff[ACC_W-1:0] : shifted;
      sreg_next_c = {sreg[LEN_REG-2:0], res_bit_c};
    end else begin
      res_bit_c   = sum[0];
      acc_next_c  = sum >> 1;
      sreg_next_c = {sum[0], sreg[LEN_REG-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv_seq.sv
// Multi-cycle mul/div sequencer for the execute stage; raises busy while iterating.
module execute_muldiv_seq
  import execute_muldiv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_REG-1:0]     data_rd,
  input  logic [LEN_REG-1:0]     data_rs,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_REG-1:0]     data_o,
  output logic [LEN_REG-1:0]     data_hi,
  output logic                   div_zero
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_div_q, op_div_d;
  logic               dz_q, dz_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_REG-1:0] sreg_q, sreg_d;
  logic [LEN_REG-1:0] opnd_q, opnd_d;
  logic               busy_d, done_d, div_zero_d;
  logic [LEN_REG-1:0] data_o_d, data_hi_d;

  logic               accept_c;
  logic [ACC_W-1:0]   acc_step_c;
  logic [LEN_REG-1:0] sreg_step_c;
  logic               qbit_c;

  assign accept_c = start && ((opecode == OPC_MUL) || (opecode == OPC_DIV));

  execute_muldiv_step u_step (
    .is_div      (op_div_q),
    .acc         (acc_q),
    .sreg        (sreg_q),
    .operand     (opnd_q),
    .acc_next_c  (acc_step_c),
    .sreg_next_c (sreg_step_c),
    .res_bit_c   (qbit_c)
  );

  // Next-state, datapath and result logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_div_d   = op_div_q;
    dz_d       = dz_q;
    acc_d      = acc_q;
    sreg_d     = sreg_q;
    opnd_d     = opnd_q;
    data_o_d   = data_o;
    data_hi_d  = data_hi;
    div_zero_d = div_zero;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (accept_c) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          op_div_d = (opecode == OPC_DIV);
          dz_d     = (opecode == OPC_DIV) && (data_rs == '0);
          sreg_d   = data_rd;
          opnd_d   = data_rs;
        end
      end
      ST_RUN: begin
        acc_d  = acc_step_c;
        sreg_d = sreg_step_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LEN_REG - 1)) begin
          state_d   = ST_DONE;
          // With a zero divisor the remainder path has shifted in the whole dividend
          data_hi_d = acc_step_c[LEN_REG-1:0];
          if (op_div_q) begin
            data_o_d   = dz_q ? '1 : {sreg_q[LEN_REG-2:0], qbit_c};
            div_zero_d = dz_q;
          end else begin
            data_o_d   = sreg_step_c;
            div_zero_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      sreg_q   <= '0;
      opnd_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_o   <= '0;
      data_hi  <= '0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
      sreg_q   <= sreg_d;
      opnd_q   <= opnd_d;
      busy     <= busy_d;
      done     <= done_d;
      data_o   <= data_o_d;
      data_hi  <= data_hi_d;
      div_zero <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// Scoreboard bench for execute_muldiv_seq: expected results queued at issue, checked at done.
module tb_execute_muldiv_seq;
  import execute_muldiv_pkg::*;

  localparam int unsigned W = LEN_REG;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [LEN_OPECODE-1:0] opecode;
  logic [W-1:0]           data_rd, data_rs;
  logic                   busy, done, div_zero;
  logic [W-1:0]           data_o, data_hi;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  execute_muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opecode  (opecode),
    .data_rd  (data_rd),
    .data_rs  (data_rs),
    .busy     (busy),
    .done     (done),
    .data_o   (data_o),
    .data_hi  (data_hi),
    .div_zero (div_zero)
  );

  function automatic exp_t model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    if (!is_div) begin
      p = (2*W)'(a) * (2*W)'(b);
      e.lo = p[W-1:0];
      e.hi = p[2*W-1:W];
      e.dz = 1'b0;
    end else if (b == '0) begin
      e.lo = '1;
      e.hi = a;
      e.dz = 1'b1;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Hold start for one edge; queue the expected result if the request should be accepted
  task automatic issue(input logic [LEN_OPECODE-1:0] opc, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit accepted);
    start   = 1'b1;
    opecode = opc;
    data_rd = a;
    data_rs = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (accepted) sb_q.push_back(model(opc == OPC_DIV, a, b));
  endtask

  // Bounded wait for done; edges counted from the accept edge
  task automatic wait_done(output int edges, output int busy_cycles, output int overlap);
    edges = 0; busy_cycles = 0; overlap = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cycles++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
      @(posedge clk); #1;
      edges++;
    end
    if (busy === 1'b1 && done === 1'b1) overlap++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opecode = '0; data_rd = '0; data_rs = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, div_zero} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl got busy=%b done=%b dz=%b want 0 0 0", busy, done, div_zero);
    end
    tests++;
    if ({data_o, data_hi} !== '0) begin
      fails++; $display("FAIL reset_data got lo=%h hi=%h want 0 0", data_o, data_hi);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_max();
    int e, b, o;
    exp_t x;
    issue(OPC_MUL, 16'hFFFF, 16'hFFFF, 1);
    wait_done(e, b, o);
    // Accept edge is cycle 1, so done after 16 more edges is cycle 17
    tests++;
    if (e + 1 !== 17) begin fails++; $display("FAIL mul_latency got %0d want 17", e + 1); end
    tests++;
    if (b !== 16) begin fails++; $display("FAIL mul_busy got %0d want 16", b); end
    tests++;
    if (o !== 0) begin fails++; $display("FAIL mul_overlap got %0d want 0", o); end
    x = sb_q.pop_front();
    tests++;
    if ({data_o, data_hi, div_zero} !== x || x.lo !== 16'h0001 || x.hi !== 16'hFFFE) begin
      fails++; $display("FAIL mul_max got lo=%h hi=%h dz=%b want lo=0001 hi=fffe dz=0", data_o, data_hi, div_zero);
    end
  endtask

  task automatic test_div();
    int e, b, o;
    exp_t x;
    issue(OPC_DIV, 16'd100, 16'd7, 1);
    wait_done(e, b, o);
    tests++;
    if (b !== 16 || o !== 0) begin fails++; $display("FAIL div_busy got busy=%0d overlap=%0d want 16 0", b, o); end
    x = sb_q.pop_front();
    tests++;
    if ({data_o, data_hi, div_zero} !== x || x.lo !== 16'h000E) begin
      fails++; $display("FAIL div_100_7 got lo=%h hi=%h dz=%b want lo=%h hi=%h dz=%b", data_o, data_hi, div_zero, x.lo, x.hi, x.dz);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL div_pulse got done=%b busy=%b want 0 0", done, busy); end
    tests++;
    if (data_o !== 16'h000E) begin fails++; $display("FAIL div_hold got %h want 000e", data_o); end
  endtask

  task automatic test_div_zero();
    int e, b, o;
    exp_t x;
    issue(OPC_DIV, 16'd1234, 16'd0, 1);
    wait_done(e, b, o);
    x = sb_q.pop_front();
    tests++;
    if ({data_o, data_hi, div_zero} !== x || e !== 16) begin
      fails++; $display("FAIL div_zero got lo=%h hi=%h dz=%b edges=%0d want lo=%h hi=%h dz=%b edges=16", data_o, data_hi, div_zero, e, x.lo, x.hi, x.dz);
    end
    @(posedge clk); #1;
    issue(OPC_MUL, 16'd3, 16'd5, 1);
    wait_done(e, b, o);
    x = sb_q.pop_front();
    tests++;
    if ({data_o, data_hi, div_zero} !== x) begin
      fails++; $display("FAIL mul_after_dz got lo=%h hi=%h dz=%b want lo=%h hi=%h dz=%b", data_o, data_hi, div_zero, x.lo, x.hi, x.dz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_opcode();
    issue(7'b001_0000, 16'd5, 16'd5, 0);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL bad_opc got busy=%b done=%b want 0 0", busy, done); end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || data_o !== 16'd15) begin fails++; $display("FAIL bad_opc_hold got busy=%b lo=%h want 0 000f", busy, data_o); end
  endtask

  task automatic test_ignored_in_run();
    int e, b, o, n_done;
    exp_t x;
    issue(OPC_MUL, 16'd7, 16'd6, 1);
    repeat (3) @(posedge clk);
    #1;
    issue(OPC_DIV, 16'd9, 16'd3, 0);
    wait_done(e, b, o);
    x = sb_q.pop_front();
    tests++;
    if ({data_o, data_hi, div_zero} !== x || x.lo !== 16'd42) begin
      fails++; $display("FAIL run_ignore got lo=%h hi=%h dz=%b want lo=002a hi=0000 dz=0", data_o, data_hi, div_zero);
    end
    n_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    tests++;
    if (n_done !== 0) begin fails++; $display("FAIL run_ignore_queued got %0d active cycles want 0", n_done); end
  endtask

  task automatic test_back_to_back();
    int e, b, o;
    exp_t x;
    issue(OPC_DIV, 16'd50, 16'd5, 1);
    wait_done(e, b, o);
    x = sb_q.pop_front();
    tests++;
    if ({data_o, data_hi, div_zero} !== x || x.lo !== 16'd10) begin
      fails++; $display("FAIL b2b_div got lo=%h hi=%h dz=%b want lo=000a hi=0000 dz=0", data_o, data_hi, div_zero);
    end
    issue(OPC_MUL, 16'd2, 16'd3, 1);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_gap got busy=%b done=%b want 1 0", busy, done); end
    wait_done(e, b, o);
    x = sb_q.pop_front();
    tests++;
    if ({data_o, data_hi, div_zero} !== x || e !== 16) begin
      fails++; $display("FAIL b2b_mul got lo=%h hi=%h dz=%b edges=%0d want lo=%h hi=%h dz=%b edges=16", data_o, data_hi, div_zero, e, x.lo, x.hi, x.dz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    issue(OPC_DIV, 16'hFFFF, 16'd1, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({busy, done, div_zero, data_o, data_hi} !== '0) begin
      fails++; $display("FAIL reset_mid got busy=%b done=%b dz=%b lo=%h hi=%h want all 0", busy, done, div_zero, data_o, data_hi);
    end
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    tests++;
    if (n_done !== 0) begin fails++; $display("FAIL reset_mid_done got %0d active cycles want 0", n_done); end
  endtask

  task automatic test_reset_and_start();
    rst = 1'b1; start = 1'b1; opecode = OPC_MUL; data_rd = 16'd3; data_rs = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_start got busy=%b want 0", busy); end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_start_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_mul_max();
    test_div();
    test_div_zero();
    test_ignored_opcode();
    test_ignored_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_and_start();
    tests++;
    if (sb_q.size() !== 0) begin fails++; $display("FAIL sb_leftover got %0d want 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
